// File: rtl/ws2812_frame_ctrl.sv
`default_nettype none
//============================================================================
// Module      : ws2812_frame_ctrl
// Description : Sequencer between the board push-button and the WS2812 bit
//               encoder. The raw button is synchronised and debounced. Each
//               press advances a 2-bit colour pattern and requests one frame
//               of NUM_LEDS identical GRB pixel words. The words go out over a
//               valid/ready handshake. The WS2812 latch gap is enforced
//               before the next frame may start.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   button     in   1   raw pad input, active-high, asynchronous to clk
//   pix_data   out  24  GRB pixel word (G[23:16], R[15:8], B[7:0])
//   pix_valid  out  1   pix_data is valid
//   pix_ready  in   1   encoder accepts the word this cycle
//   busy       out  1   frame in progress (SEND or LATCH)
//   pattern    out  2   current colour pattern
//   led1       out  1   debounced button level
//============================================================================
module ws2812_frame_ctrl #(
    parameter int NUM_LEDS        = 8,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LATCH_CYCLES    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic [1:0]  pattern,
    output logic        led1
);

    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int c_LATCH_W = $clog2(LATCH_CYCLES + 1);
    localparam int c_IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [c_DB_W-1:0]    c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_LATCH_W-1:0] c_LATCH_LAST = c_LATCH_W'(LATCH_CYCLES - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'(NUM_LEDS - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SEND  = 2'd1;
    localparam logic [1:0] c_ST_LATCH = 2'd2;

    // GRB colour map for each pattern value.
    function automatic logic [23:0] colour_of(input logic [1:0] p);
        case (p)
            2'd1:    colour_of = 24'h00FF00;
            2'd2:    colour_of = 24'hFF0000;
            2'd3:    colour_of = 24'h0000FF;
            default: colour_of = 24'h000000;
        endcase
    endfunction

    //------------------------------------------------------------------------
    // Synchroniser and debouncer
    //------------------------------------------------------------------------
    logic              r_sync_q1;
    logic              r_btn_s;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_stable;
    logic              r_stable_d;
    logic              w_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_q1  <= 1'b0;
            r_btn_s    <= 1'b0;
            r_db_cnt   <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_sync_q1  <= button;
            r_btn_s    <= r_sync_q1;
            r_stable_d <= r_stable;
            // The counter only runs while the synced level disagrees with the
            // accepted one, so any return to the old level restarts the count.
            if (r_btn_s != r_stable) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_stable <= r_btn_s;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Rising edge of the debounced level only; release is not an event.
    assign w_press = r_stable & ~r_stable_d;

    //------------------------------------------------------------------------
    // Frame FSM and datapath
    //------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_busy;
    logic [1:0]           r_pattern;
    logic [1:0]           w_pattern_nxt;
    logic                 r_pending;
    logic                 w_pending_nxt;
    logic [c_IDX_W-1:0]   r_pix_idx;
    logic [c_IDX_W-1:0]   w_pix_idx_nxt;
    logic [c_LATCH_W-1:0] r_latch_cnt;
    logic [c_LATCH_W-1:0] w_latch_cnt_nxt;
    logic [23:0]          r_pix_data;
    logic [23:0]          w_pix_data_nxt;
    logic                 r_pix_valid;
    logic                 w_pix_valid_nxt;
    logic                 w_start;
    logic                 w_xfer;
    logic                 w_last;

    assign w_pattern_nxt = w_press ? (r_pattern + 2'd1) : r_pattern;
    assign w_start       = w_press | r_pending;
    assign w_xfer        = r_pix_valid & pix_ready;
    assign w_last        = (r_pix_idx == c_IDX_LAST);

    // State register; busy is registered alongside so it tracks the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_ST_IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_start) w_state_nxt = c_ST_SEND;
            c_ST_SEND:  if (w_xfer && w_last) w_state_nxt = c_ST_LATCH;
            c_ST_LATCH: if (r_latch_cnt == c_LATCH_LAST) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        w_pix_data_nxt  = r_pix_data;
        w_pix_valid_nxt = r_pix_valid;
        w_pix_idx_nxt   = r_pix_idx;
        w_latch_cnt_nxt = r_latch_cnt;
        w_pending_nxt   = r_pending;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    // Colour comes from the pattern as it will be after this
                    // edge, so a press and its frame always agree.
                    w_pix_data_nxt  = colour_of(w_pattern_nxt);
                    w_pix_valid_nxt = 1'b1;
                    w_pix_idx_nxt   = '0;
                    w_pending_nxt   = 1'b0;
                end
            end
            c_ST_SEND: begin
                w_pending_nxt = r_pending | w_press;
                if (w_xfer) begin
                    if (w_last) begin
                        w_pix_valid_nxt = 1'b0;
                        w_latch_cnt_nxt = '0;
                    end else begin
                        w_pix_idx_nxt = r_pix_idx + 1'b1;
                    end
                end
            end
            c_ST_LATCH: begin
                w_pending_nxt   = r_pending | w_press;
                w_latch_cnt_nxt = r_latch_cnt + 1'b1;
            end
            default: begin
                w_pix_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern   <= 2'd0;
            r_pending   <= 1'b0;
            r_pix_idx   <= '0;
            r_latch_cnt <= '0;
            r_pix_data  <= 24'h000000;
            r_pix_valid <= 1'b0;
        end else begin
            r_pattern   <= w_pattern_nxt;
            r_pending   <= w_pending_nxt;
            r_pix_idx   <= w_pix_idx_nxt;
            r_latch_cnt <= w_latch_cnt_nxt;
            r_pix_data  <= w_pix_data_nxt;
            r_pix_valid <= w_pix_valid_nxt;
        end
    end

    assign pix_data  = r_pix_data;
    assign pix_valid = r_pix_valid;
    assign busy      = r_busy;
    assign pattern   = r_pattern;
    assign led1      = r_stable;

endmodule
`default_nettype wire

// File: doc/ws2812_frame_ctrl.md
Name: ws2812_frame_ctrl

Overview:
- Sequencer between the board push-button and the WS2812 bit encoder.
- Synchronises and debounces the raw button. Each press advances a 2-bit colour pattern.
- Streams one frame of NUM_LEDS 24-bit GRB pixel words to the encoder over a valid/ready handshake, then enforces the WS2812 latch gap.
- Replaces the direct button-to-LED register path. led1 now mirrors the debounced button state.

Parameters:
- NUM_LEDS, 8, pixels per frame (>=1).
- DEBOUNCE_CYCLES, 240000, cycles the synced input must hold a new level before it is accepted (>=2; 20 ms at 12 MHz).
- LATCH_CYCLES, 1000, idle cycles after the last pixel before a new frame may start (>=1; >50 us at 12 MHz).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- button  in  1  raw pad input, active-high, asynchronous to clk.
- pix_data  out  24  GRB pixel word to the encoder (G[23:16], R[15:8], B[7:0]).
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  encoder accepts the word this cycle.
- busy  out  1  frame in progress (SEND or LATCH).
- pattern  out  2  current colour pattern.
- led1  out  1  debounced button level.

Behaviour:
- Reset (async, active-high) clears every register: pix_data=0, pix_valid=0, busy=0, pattern=0, led1=0, FSM=IDLE, pending=0, all counters 0.
- Input synchroniser: 2-flop chain on button; its output is btn_s.
- Debouncer:
  - If btn_s != stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 in that condition: stable <= btn_s and the counter clears.
  - If btn_s == stable, the counter clears. A glitch shorter than DEBOUNCE_CYCLES therefore never changes stable.
  - led1 = stable.
  - press = one-cycle pulse on a 0->1 edge of stable. Release produces no event.
- Pattern:
  - On press, pattern <= pattern+1, mod 4 (3 wraps to 0).
  - Colour map: 0 -> 0x000000, 1 -> 0x00FF00 (red), 2 -> 0xFF0000 (green), 3 -> 0x0000FF (blue).
- FSM states IDLE, SEND, LATCH:
  - IDLE: if press or pending, go to SEND. On that edge: pix_data <= colour of the post-increment pattern, pix_valid <= 1, pix_idx <= 0, pending <= 0. So pix_valid rises the cycle after the press pulse.
  - SEND: a transfer happens when pix_valid && pix_ready.
    - Transfer with pix_idx < NUM_LEDS-1: pix_idx increments and pix_valid stays 1.
    - Transfer with pix_idx == NUM_LEDS-1: pix_valid <= 0 on the same edge, latch counter clears, go to LATCH.
    - pix_data is held constant for the whole frame, including stalls. pix_valid never drops without a transfer.
  - LATCH: the counter increments each cycle. After LATCH_CYCLES cycles in LATCH, go to IDLE.
- busy = (state != IDLE), registered with the state.
- A press during SEND or LATCH updates pattern immediately and sets pending. It does not alter the frame in flight.
- Multiple presses while busy coalesce into one pending frame. That frame uses the final pattern.
- pending is serviced on the cycle IDLE is entered: a single IDLE cycle, then SEND.
- press while pending is already set: pattern increments, pending stays 1.
- pix_ready is ignored outside SEND.
- Reset asserted mid-frame aborts immediately. pix_valid drops asynchronously and no pending frame survives.
- Widths:
  - Debounce counter: clog2(DEBOUNCE_CYCLES).
  - Latch counter: clog2(LATCH_CYCLES+1).
  - pix_idx: clog2(NUM_LEDS), minimum 1 bit.
  - No overflow is reachable.

Test Plan (DEBOUNCE_CYCLES=4, NUM_LEDS=3, LATCH_CYCLES=5 unless stated):
- Reset then idle: rst pulse, button=0, pix_ready=1 -> all outputs 0, no pix_valid for 50 cycles.
- Debounce: button high for 3 cycles then low -> led1 stays 0 and pattern stays 0. Button high held -> led1 rises exactly 2+4 cycles after the button edge; pattern=1.
- Frame with stalls:
  - Stimulus: one press, pix_ready toggling 1,0,0,1,...
  - pix_valid rises the cycle after press and holds 0x00FF00 through stalls.
  - Exactly 3 transfers occur; pix_valid falls on the edge of the 3rd.
  - busy stays high for a further 5 cycles, then falls.
- Coalescing: with pattern=1 and busy, press twice during SEND -> pattern=3. After LATCH, exactly one extra frame of 0x0000FF, starting 1 cycle after IDLE is entered.
- Wrap: 4 presses spaced beyond the frame duration -> frames 0x00FF00, 0xFF0000, 0x0000FF, 0x000000; pattern returns to 0.
- Mid-frame reset: assert rst after the 1st transfer -> pix_valid and busy drop with no clock edge. After release no frame is emitted until a new press.
